// File: rtl/shift_reg_pkg.sv
// Purpose : shared mode encodings and shift-direction type for the universal shift register.
// Latency : n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   MODE_HOLD / MODE_SHL / MODE_SHR / MODE_LOAD : 2-bit operation codes on the mode port
//   dir_e                                      : direction of the most recent shift
package shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;  // LSB toward MSB, fill enters bit 0
  localparam logic [1:0] MODE_SHR  = 2'b10;  // MSB toward LSB, fill enters bit WIDTH-1
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

endpackage : shift_reg_pkg

// File: rtl/shift_bit_counter.sv
// Purpose : counts consecutive same-direction shifts modulo WIDTH and flags each completed word.
// Latency : shift_count and word_valid are registered, one edge after the strobe is sampled.
// Backpressure: none; a strobe is consumed on every edge it is presented.
//
// Ports:
//   clk, clear_n   : clock and synchronous active-low clear
//   shift_vld      : a shift happens on this edge
//   shift_dir      : direction of that shift
//   load           : parallel load on this edge (restarts the count)
//   shift_count    : consecutive same-direction shifts modulo WIDTH
//   word_valid     : one-cycle pulse after the edge that completes WIDTH same-direction shifts
module shift_bit_counter
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             shift_vld,
  input  dir_e             shift_dir,
  input  logic             load,
  output logic [CNT_W-1:0] shift_count,
  output logic             word_valid
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  dir_e             dir_q,   dir_d;

  // After a load or clear the count is 0, so the next shift lands on 1
  // whichever way it goes: same direction increments 0->1, the opposite
  // direction restarts at 1. No separate "fresh" flag is needed.
  always_comb begin
    count_d = count_q;
    valid_d = 1'b0;  // pulse only; any edge without a completing shift drops it
    dir_d   = dir_q;
    if (load) begin
      count_d = '0;
    end else if (shift_vld) begin
      if (shift_dir == dir_q) begin
        if (count_q == CNT_LAST) begin
          count_d = '0;
          valid_d = 1'b1;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end else begin
        // Direction change: this bit is the first of a new word.
        count_d = CNT_ONE;
        dir_d   = shift_dir;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count_q <= '0;
      valid_q <= 1'b0;
      dir_q   <= DIR_LEFT;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
      dir_q   <= dir_d;
    end
  end

  assign shift_count = count_q;
  assign word_valid  = valid_q;

endmodule : shift_bit_counter

// File: rtl/register_shift_universal_n_bit.sv
// Purpose : universal shift register (hold / shift left / shift right / parallel load) usable as SIPO, PISO or SISO.
// Latency : every output is registered and reflects the operation one clock edge after it is sampled.
// Backpressure: none; an operation is accepted on every edge, and hold is the only way to stall.
//
// Ports:
//   clk, clear_n   : clock and synchronous active-low clear (overrides mode)
//   mode           : 00 hold, 01 shift left, 10 shift right, 11 load
//   serial_in      : fill bit (bit 0 on left shift, bit WIDTH-1 on right shift)
//   parallel_in    : load data for mode 11
//   parallel_out   : register contents
//   serial_out     : registered copy of the bit that left on the last shift (0 after load/clear)
//   word_valid     : one-cycle pulse when WIDTH same-direction shifts have completed a word
//   shift_count    : consecutive same-direction shifts modulo WIDTH
module register_shift_universal_n_bit
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out,
  output logic             word_valid,
  output logic [CNT_W-1:0] shift_count
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             sout_q, sout_d;
  logic             shift_vld;
  dir_e             shift_dir;
  logic             load;

  // Operation decode and next data. Any code not listed (including an
  // unknown mode) falls through to the defaults, i.e. hold.
  always_comb begin
    data_d    = data_q;
    sout_d    = sout_q;
    shift_vld = 1'b0;
    shift_dir = DIR_LEFT;
    load      = 1'b0;
    case (mode)
      MODE_SHL: begin
        data_d    = {data_q[WIDTH-2:0], serial_in};
        sout_d    = data_q[WIDTH-1];
        shift_vld = 1'b1;
        shift_dir = DIR_LEFT;
      end
      MODE_SHR: begin
        data_d    = {serial_in, data_q[WIDTH-1:1]};
        sout_d    = data_q[0];
        shift_vld = 1'b1;
        shift_dir = DIR_RIGHT;
      end
      MODE_LOAD: begin
        data_d = parallel_in;
        sout_d = 1'b0;
        load   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      data_q <= '0;
      sout_q <= 1'b0;
    end else begin
      data_q <= data_d;
      sout_q <= sout_d;
    end
  end

  shift_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk         (clk),
    .clear_n     (clear_n),
    .shift_vld   (shift_vld),
    .shift_dir   (shift_dir),
    .load        (load),
    .shift_count (shift_count),
    .word_valid  (word_valid)
  );

  assign parallel_out = data_q;
  assign serial_out   = sout_q;

endmodule : register_shift_universal_n_bit

// File: tb/tb_register_shift_universal_n_bit.sv
// Purpose : self-checking bench for register_shift_universal_n_bit at WIDTH = 4.
// Latency : outputs are sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_register_shift_universal_n_bit;

  localparam int W = 4;

  logic         clk;
  logic         clear_n;
  logic [1:0]   mode;
  logic         serial_in;
  logic [W-1:0] parallel_in;
  logic [W-1:0] parallel_out;
  logic         serial_out;
  logic         word_valid;
  logic [1:0]   shift_count;

  int checks;
  int errors;

  register_shift_universal_n_bit #(.WIDTH(W)) dut (
    .clk          (clk),
    .clear_n      (clear_n),
    .mode         (mode),
    .serial_in    (serial_in),
    .parallel_in  (parallel_in),
    .parallel_out (parallel_out),
    .serial_out   (serial_out),
    .word_valid   (word_valid),
    .shift_count  (shift_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       cn;
    logic [1:0] md;
    logic       si;
    logic [3:0] pin;
    logic [3:0] po;
    logic       so;
    logic       wv;
    logic [1:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one operation away from the active edge, then sample after it.
  task automatic apply(input logic cn, input logic [1:0] md, input logic si, input logic [3:0] pin);
    @(negedge clk);
    clear_n     = cn;
    mode        = md;
    serial_in   = si;
    parallel_in = pin;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string nm, input logic cn, input logic [1:0] md, input logic si,
                      input logic [3:0] pin, input logic [3:0] po, input logic so,
                      input logic wv, input logic [1:0] cnt);
    apply(cn, md, si, pin);
    chk({nm, ".po"},  32'(parallel_out), 32'(po));
    chk({nm, ".so"},  32'(serial_out),   32'(so));
    chk({nm, ".wv"},  32'(word_valid),   32'(wv));
    chk({nm, ".cnt"}, 32'(shift_count),  32'(cnt));
  endtask

  // Reference model: register as an integer, counting as a run length of
  // consecutive same-direction shifts (0 = no shift since load/clear).
  int m_po, m_so, m_wv, m_run, m_last;

  task automatic model(input logic cn, input logic [1:0] md, input logic si, input logic [3:0] pin);
    int dir;
    bit sh;
    sh = 0;
    dir = 0;
    if (!cn) begin
      m_po = 0; m_so = 0; m_wv = 0; m_run = 0; m_last = 0;
    end else begin
      case (md)
        2'b00: m_wv = 0;
        2'b01: begin
          m_so = (m_po >> (W - 1)) & 1;
          m_po = ((m_po << 1) | int'(si)) % (1 << W);
          sh = 1; dir = 0;
        end
        2'b10: begin
          m_so = m_po & 1;
          m_po = (m_po >> 1) | (int'(si) << (W - 1));
          sh = 1; dir = 1;
        end
        default: begin
          m_po = int'(pin); m_so = 0; m_run = 0; m_wv = 0;
        end
      endcase
      if (sh) begin
        m_run  = (m_run > 0 && dir == m_last) ? m_run + 1 : 1;
        m_last = dir;
        m_wv   = (m_run % W == 0) ? 1 : 0;
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    clear_n     = 1'b0;
    mode        = 2'b00;
    serial_in   = 1'b0;
    parallel_in = '0;

    // name, clear_n, mode, serial_in, parallel_in | parallel_out, serial_out, word_valid, shift_count
    tbl.push_back('{"rst",   1'b0, 2'b01, 1'b1, 4'h0, 4'b0000, 1'b0, 1'b0, 2'd0});
    tbl.push_back('{"shl1",  1'b1, 2'b01, 1'b1, 4'h0, 4'b0001, 1'b0, 1'b0, 2'd1});
    tbl.push_back('{"shl2",  1'b1, 2'b01, 1'b0, 4'h0, 4'b0010, 1'b0, 1'b0, 2'd2});
    tbl.push_back('{"shl3",  1'b1, 2'b01, 1'b1, 4'h0, 4'b0101, 1'b0, 1'b0, 2'd3});
    tbl.push_back('{"shl4",  1'b1, 2'b01, 1'b1, 4'h0, 4'b1011, 1'b0, 1'b1, 2'd0});
    tbl.push_back('{"hold",  1'b1, 2'b00, 1'b1, 4'hF, 4'b1011, 1'b0, 1'b0, 2'd0});
    tbl.push_back('{"rst2",  1'b0, 2'b11, 1'b0, 4'hF, 4'b0000, 1'b0, 1'b0, 2'd0});
    tbl.push_back('{"shr1",  1'b1, 2'b10, 1'b1, 4'h0, 4'b1000, 1'b0, 1'b0, 2'd1});
    tbl.push_back('{"shr2",  1'b1, 2'b10, 1'b0, 4'h0, 4'b0100, 1'b0, 1'b0, 2'd2});
    tbl.push_back('{"shr3",  1'b1, 2'b10, 1'b0, 4'h0, 4'b0010, 1'b0, 1'b0, 2'd3});
    tbl.push_back('{"shr4",  1'b1, 2'b10, 1'b1, 4'h0, 4'b1001, 1'b0, 1'b1, 2'd0});
    tbl.push_back('{"load",  1'b1, 2'b11, 1'b1, 4'h6, 4'b0110, 1'b0, 1'b0, 2'd0});
    tbl.push_back('{"lshl1", 1'b1, 2'b01, 1'b0, 4'h0, 4'b1100, 1'b0, 1'b0, 2'd1});
    tbl.push_back('{"lshl2", 1'b1, 2'b01, 1'b0, 4'h0, 4'b1000, 1'b1, 1'b0, 2'd2});

    foreach (tbl[i])
      step(tbl[i].name, tbl[i].cn, tbl[i].md, tbl[i].si, tbl[i].pin,
           tbl[i].po, tbl[i].so, tbl[i].wv, tbl[i].cnt);

    // Direction reversal mid-word restarts the count at 1.
    step("rev_rst", 1'b0, 2'b00, 1'b0, 4'h0, 4'b0000, 1'b0, 1'b0, 2'd0);
    step("rev_l1",  1'b1, 2'b01, 1'b0, 4'h0, 4'b0000, 1'b0, 1'b0, 2'd1);
    step("rev_l2",  1'b1, 2'b01, 1'b0, 4'h0, 4'b0000, 1'b0, 1'b0, 2'd2);
    step("rev_r1",  1'b1, 2'b10, 1'b0, 4'h0, 4'b0000, 1'b0, 1'b0, 2'd1);
    step("rev_r2",  1'b1, 2'b10, 1'b0, 4'h0, 4'b0000, 1'b0, 1'b0, 2'd2);
    step("rev_r3",  1'b1, 2'b10, 1'b0, 4'h0, 4'b0000, 1'b0, 1'b0, 2'd3);
    step("rev_r4",  1'b1, 2'b10, 1'b0, 4'h0, 4'b0000, 1'b0, 1'b1, 2'd0);

    // Clear mid-word discards the partial count; holds between shifts change nothing.
    step("mid_l1",  1'b1, 2'b01, 1'b1, 4'h0, 4'b0001, 1'b0, 1'b0, 2'd1);
    step("mid_l2",  1'b1, 2'b01, 1'b1, 4'h0, 4'b0011, 1'b0, 1'b0, 2'd2);
    step("mid_l3",  1'b1, 2'b01, 1'b1, 4'h0, 4'b0111, 1'b0, 1'b0, 2'd3);
    step("mid_rst", 1'b0, 2'b01, 1'b1, 4'h0, 4'b0000, 1'b0, 1'b0, 2'd0);
    step("mid_h0",  1'b1, 2'b00, 1'b1, 4'h0, 4'b0000, 1'b0, 1'b0, 2'd0);
    step("post_l1", 1'b1, 2'b01, 1'b1, 4'h0, 4'b0001, 1'b0, 1'b0, 2'd1);
    step("post_h1", 1'b1, 2'b00, 1'b0, 4'h9, 4'b0001, 1'b0, 1'b0, 2'd1);
    step("post_l2", 1'b1, 2'b01, 1'b1, 4'h0, 4'b0011, 1'b0, 1'b0, 2'd2);
    step("post_l3", 1'b1, 2'b01, 1'b1, 4'h0, 4'b0111, 1'b0, 1'b0, 2'd3);
    step("post_h3", 1'b1, 2'b00, 1'b0, 4'h0, 4'b0111, 1'b0, 1'b0, 2'd3);
    step("post_l4", 1'b1, 2'b01, 1'b1, 4'h0, 4'b1111, 1'b0, 1'b1, 2'd0);
    step("post_h4", 1'b1, 2'b00, 1'b0, 4'h0, 4'b1111, 1'b0, 1'b0, 2'd0);

    // Randomized run against the reference model, starting from a clear.
    apply(1'b0, 2'b00, 1'b0, 4'h0);
    model(1'b0, 2'b00, 1'b0, 4'h0);
    for (int n = 0; n < 600; n++) begin
      logic       cn;
      logic [1:0] md;
      logic       si;
      logic [3:0] pin;
      cn  = ($urandom_range(31, 0) != 0);
      // Bias toward shifts so words complete often, with occasional reversals.
      case ($urandom_range(9, 0))
        0:       md = 2'b00;
        1:       md = 2'b11;
        2, 3:    md = 2'b10;
        default: md = ($urandom_range(5, 0) == 0) ? 2'b10 : 2'b01;
      endcase
      si  = 1'($urandom);
      pin = 4'($urandom);
      apply(cn, md, si, pin);
      model(cn, md, si, pin);
      chk("rnd.po",  32'(parallel_out), 32'(m_po));
      chk("rnd.so",  32'(serial_out),   32'(m_so));
      chk("rnd.wv",  32'(word_valid),   32'(m_wv));
      chk("rnd.cnt", 32'(shift_count),  32'(m_run % W));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_register_shift_universal_n_bit

// File: doc/register_shift_universal_n_bit.md
Name: register_shift_universal_n_bit

Overview:
- Parametrised universal shift register: hold, shift left, shift right and parallel load on a single clock.
- Acts as the datapath's serial/parallel converter, usable as SIPO, PISO or SISO.
- Adds a shift counter that pulses word_valid once WIDTH bits have been shifted in one direction, so downstream logic can capture assembled words without its own bit counting.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), shift-counter width; derived, never overridden.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- clear_n, input, 1, reset; synchronous, active-low; sampled on rising edge of clk.
- mode, input, 2, 00 = hold, 01 = shift left (LSB toward MSB), 10 = shift right (MSB toward LSB), 11 = parallel load.
- serial_in, input, 1, fill bit: enters bit 0 on left shift, bit WIDTH-1 on right shift.
- parallel_in, input, WIDTH, load data for mode 11.
- parallel_out, output, WIDTH, register contents.
- serial_out, output, 1, registered copy of the bit that exited on the last shift.
- word_valid, output, 1, one-cycle pulse marking a completed WIDTH-bit word.
- shift_count, output, CNT_W, consecutive same-direction shifts modulo WIDTH.

Behaviour:
- Reset (clear_n = 0 at an edge): parallel_out = 0, serial_out = 0, word_valid = 0, shift_count = 0, last direction = left. Reset overrides mode, including mid-word; partial counts are discarded.
- Hold (00): all state unchanged; word_valid deasserts to 0.
- Shift left (01):
  - parallel_out <= {parallel_out[WIDTH-2:0], serial_in}.
  - serial_out <= old parallel_out[WIDTH-1].
- Shift right (10):
  - parallel_out <= {serial_in, parallel_out[WIDTH-1:1]}.
  - serial_out <= old parallel_out[0].
- Load (11): parallel_out <= parallel_in; serial_out <= 0; shift_count <= 0; word_valid <= 0.
- Counter on a shift in the same direction as the last shift:
  - If shift_count = WIDTH-1, shift_count wraps to 0 and word_valid <= 1.
  - Otherwise shift_count increments and word_valid <= 0.
- Counter on a shift in the opposite direction: shift_count <= 1, word_valid <= 0, last direction updated. The new direction's bit counts as the first of a new word.
- After a load or reset, the next shift in either direction counts as bit 1 and sets last direction.
- word_valid timing: registered, high for the single cycle following the edge that completes the word. It coincides with parallel_out holding the full word. Back-to-back words pulse every WIDTH shifts with no gap cycle required.
- Latency: parallel_out, serial_out and shift_count reflect an operation one edge after it is sampled. No combinational path exists from inputs to outputs.
- Illegal or X mode: treated as hold.

Decomposition:
- Shared package shift_reg_pkg holds:
  - mode encodings MODE_HOLD, MODE_SHL, MODE_SHR, MODE_LOAD;
  - the direction enum DIR_LEFT/DIR_RIGHT.
- One natural sub-module, shift_bit_counter. It takes WIDTH, shift strobe, direction, load and clear_n, and produces shift_count and word_valid.
- The data register stays in the top module.

Test Plan:
- WIDTH = 4. clear_n = 0 for one edge with mode = 01 and serial_in = 1 -> parallel_out = 0000, serial_out = 0, word_valid = 0, shift_count = 0.
- Left shifts of serial_in 1,0,1,1 -> parallel_out 0001, 0010, 0101, 1011. shift_count goes 1, 2, 3, 0. word_valid is high only in the cycle showing 1011.
- From 0000, right shifts of serial_in 1,0,0,1 -> parallel_out 1000, 0100, 0010, 1001. word_valid pulses once after the 4th shift. serial_out stays 0 throughout.
- Load parallel_in = 0110, then two left shifts with serial_in = 0 -> 0110 (serial_out 0), then 1100 (serial_out 0), then 1000 (serial_out 1). word_valid stays 0.
- Two left shifts, then a right shift -> shift_count = 1. Three further right shifts are required before word_valid pulses; no pulse appears at the 4th total shift.
- Three left shifts, clear_n = 0 for one edge, then four left shifts of 1 -> outputs clear to 0 and count restarts. word_valid pulses only on the 4th post-reset shift with parallel_out = 1111. Hold cycles inserted between shifts leave all outputs unchanged.
